// File: rtl/msk_and_hpc2_sched.sv
// msk_and_hpc2_sched: round-robin issue scheduler sharing one latency-2 HPC2 masked AND gadget.
// Optional build macro MSKSCHED_ZEROIZE_EN zeroes gadget inputs and rsp_data on bubble cycles.
module msk_and_hpc2_sched #(
   parameter int d    = 2,
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ),
   parameter int RND  = d*(d-1)/2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*d-1:0] req_a,
   input  logic [NREQ*d-1:0] req_b,
   input  logic [RND-1:0]    rnd_in,
   input  logic              rnd_valid,
   output logic              rnd_ready,
   output logic [d-1:0]      g_ina,
   output logic [RND-1:0]    g_rnd,
   output logic [d-1:0]      g_inb,
   output logic [d-1:0]      g_ina_prev,
   input  logic [d-1:0]      g_out,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [d-1:0]      rsp_data,
   output logic              idle
);
   logic [IDW-1:0] ptr_q, ptr_d, cand, idx, id1_q, id1_d, id2_q;
   logic [d-1:0]   a1_q, a1_d, b1_q, b1_d, a_sel, b_sel;
   logic           v1_q, v2_q, issue, found;
   // Candidate is the first valid index after ptr; with no valid request it is ptr+1.
   always_comb begin
      cand  = IDW'((int'(ptr_q) + 1) % NREQ);
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(ptr_q) + k) % NREQ);
         if (!found && req_valid[idx]) begin
            cand  = idx;
            found = 1'b1;
         end
      end
   end
   assign issue      = rnd_valid & |req_valid;
   assign rnd_ready  = issue;
   assign req_ready  = issue ? NREQ'(1) << cand : '0;
   assign a_sel      = req_a[cand*d +: d];
   assign b_sel      = req_b[cand*d +: d];
   assign ptr_d      = issue ? cand : ptr_q;
   assign id1_d      = issue ? cand : id1_q;
   assign g_inb      = b1_q;
   assign g_ina_prev = a1_q;
   assign rsp_valid  = v2_q;
   assign rsp_id     = id2_q;
   assign idle       = ~v1_q & ~v2_q & ~issue;
`ifdef MSKSCHED_ZEROIZE_EN
   assign g_ina    = issue ? a_sel : '0;
   assign g_rnd    = issue ? rnd_in : '0;
   assign a1_d     = issue ? a_sel : '0;
   assign b1_d     = issue ? b_sel : '0;
   assign rsp_data = v2_q ? g_out : '0;
`else
   assign g_ina    = a_sel;
   assign g_rnd    = rnd_in;
   assign a1_d     = issue ? a_sel : a1_q;
   assign b1_d     = issue ? b_sel : b1_q;
   assign rsp_data = g_out;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= IDW'(NREQ - 1);
         a1_q  <= '0;
         b1_q  <= '0;
         id1_q <= '0;
         id2_q <= '0;
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         a1_q  <= a1_d;
         b1_q  <= b1_d;
         id1_q <= id1_d;
         id2_q <= id1_q;
         v1_q  <= issue;
         v2_q  <= v1_q;
      end
   end
endmodule
